// File: rtl/psum_accumulator_if.sv
// Handshake bundle for the partial-sum accumulator.
// Input and output streams use valid/ready handshakes, plus status outputs.
interface psum_accumulator_if #(
    parameter int BIT_WIDTH = 16
) ();
    logic [BIT_WIDTH-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [BIT_WIDTH-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_ovf;
    logic [7:0]           term_cnt;

    // Source/sink side (drives terms, consumes results)
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ovf, term_cnt
    );

    // Accumulator side
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ovf, term_cnt
    );
endinterface

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: adds NUM_TERMS signed terms using an approximate adder.
// In the adder, the low APPROX_BITS come straight from the incoming term.
// The top bits get an exact add, with a carry-in taken from acc[APPROX_BITS-1].
// The first term of each group is loaded directly. The result is held in DONE until it is taken.
module psum_accumulator #(
    parameter int BIT_WIDTH   = 16,
    parameter int APPROX_BITS = 6,
    parameter int NUM_TERMS   = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    psum_accumulator_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    localparam logic [BIT_WIDTH-1:0] ONE     = BIT_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0] LO_MASK = (ONE << APPROX_BITS) - ONE;
    localparam logic [BIT_WIDTH-1:0] HI_MASK = ~LO_MASK;
    localparam logic [7:0]           LAST_M1 = 8'(NUM_TERMS - 1);

    state_t               state, state_nxt;
    logic [BIT_WIDTH-1:0] acc;
    logic [BIT_WIDTH-1:0] sum;
    logic [BIT_WIDTH-1:0] cin_vec;
    logic [7:0]           cnt;
    logic                 ovf;
    logic                 step_ovf;
    logic                 cin;
    logic                 in_hs;
    logic                 out_hs;
    logic                 in_ready;
    logic                 out_valid;

    // The carry-in to the exact part comes from the top discarded bit of the accumulator
    if (APPROX_BITS > 0) begin : g_cin
        assign cin = acc[APPROX_BITS-1];
    end else begin : g_nocin
        assign cin = 1'b0;
    end

    // Approximate add. The masked operands have zero low bits, so the low bits of the
    // sum are zero, and OR-ing in the low bits of the term is exact.
    always_comb begin
        cin_vec  = {{(BIT_WIDTH-1){1'b0}}, cin} << APPROX_BITS;
        sum      = ((acc & HI_MASK) + (bus.in_data & HI_MASK) + cin_vec)
                 | (bus.in_data & LO_MASK);
        step_ovf = (acc[BIT_WIDTH-1] == bus.in_data[BIT_WIDTH-1]) &&
                   (sum[BIT_WIDTH-1] != acc[BIT_WIDTH-1]);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and handshake decode
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b1;
        out_valid = 1'b0;
        in_hs     = 1'b0;
        out_hs    = 1'b0;
        case (state)
            IDLE: begin
                in_hs = bus.in_valid;
                if (in_hs) state_nxt = (NUM_TERMS == 1) ? DONE : ACCUM;
            end
            ACCUM: begin
                in_hs = bus.in_valid;
                if (in_hs && cnt == LAST_M1) state_nxt = DONE;
            end
            DONE: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                out_hs    = bus.out_ready;
                if (out_hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator, term counter and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (in_hs) begin
            if (state == IDLE) begin
                acc <= bus.in_data;
                cnt <= 8'd1;
                ovf <= 1'b0;
            end else begin
                acc <= sum;
                cnt <= cnt + 8'd1;
                ovf <= ovf | step_ovf;
            end
        end else if (out_hs) begin
            cnt <= '0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = acc;
    assign bus.out_ovf   = ovf;
    assign bus.term_cnt  = cnt;
endmodule
